// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the sequential fp32 multiplier.
package fp_mul_pkg;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC00000;

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} cls_t;

  // Subnormals land in ZERO: they are flushed.
  function automatic cls_t classify(input fp32_t x);
    if (x.exp == 8'd0)   return ZERO;
    if (x.exp != 8'hFF)  return NORMAL;
    return (x.frac == '0) ? INF : NAN;
  endfunction

endpackage

// File: rtl/fp_mul_rca.sv
// Ripple-carry adder chain used for the mantissa accumulate.
module fp_mul_rca #(
  parameter int W = 24
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W:0] c;

  assign c[0] = i_cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign o_sum[i] = i_a[i] ^ i_b[i] ^ c[i];
    assign c[i+1]   = (i_a[i] & i_b[i]) | (c[i] & (i_a[i] ^ i_b[i]));
  end

  assign o_cout = c[W];

endmodule

// File: rtl/fp_mul_round.sv
// Normalize, round and apply special/range overrides to a raw product.
// FP_MUL_ROUND_EN selects round-to-nearest-even; otherwise truncate.
module fp_mul_round
  import fp_mul_pkg::*;
#(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic [2*MANT_W-1:0]     i_prod,
  input  logic signed [EXP_W+1:0] i_exp,
  input  logic                    i_sign,
  input  cls_t                    i_cls_a,
  input  cls_t                    i_cls_b,
  output logic [31:0]             o_data,
  output logic [2:0]              o_flags
);

  localparam int PW   = 2 * MANT_W;
  localparam int F    = MANT_W - 1;
  localparam int SE_W = EXP_W + 2;
  localparam logic signed [SE_W-1:0] EXP_OVF  = SE_W'(EXP_MAX);
  localparam logic signed [SE_W-1:0] EXP_ZERO = '0;

  logic                   hi;
  logic [F-1:0]           mant;
  logic signed [SE_W-1:0] exp_n;
  logic [F-1:0]           unused_lo;
  logic                   any_nan, any_inf, any_zero;
`ifdef FP_MUL_ROUND_EN
  logic                   guard, sticky;
  logic [F:0]             mant_rnd;
`endif

  assign unused_lo = i_prod[F-1:0];
  assign any_nan   = (i_cls_a == NAN)  || (i_cls_b == NAN);
  assign any_inf   = (i_cls_a == INF)  || (i_cls_b == INF);
  assign any_zero  = (i_cls_a == ZERO) || (i_cls_b == ZERO);

  // Product is in [1,4): pick the leading one, round, then override.
  always_comb begin
    hi    = i_prod[PW-1];
    mant  = hi ? i_prod[PW-2 -: F] : i_prod[PW-3 -: F];
    exp_n = i_exp + SE_W'(hi);
`ifdef FP_MUL_ROUND_EN
    guard    = hi ? i_prod[F] : i_prod[F-1];
    sticky   = hi ? |i_prod[F-1:0] : |i_prod[F-2:0];
    mant_rnd = {1'b0, mant};
    if (guard && (sticky || mant[0])) begin
      mant_rnd = {1'b0, mant} + (F+1)'(1);
      // Carry out leaves the fraction at zero and bumps the exponent.
      mant     = mant_rnd[F-1:0];
      exp_n    = exp_n + SE_W'(mant_rnd[F]);
    end
`endif
    o_flags = 3'b000;
    if (any_nan || (any_inf && any_zero)) begin
      o_data  = QNAN;
      o_flags = 3'b100;
    end else if (any_inf) begin
      o_data = {i_sign, {EXP_W{1'b1}}, {F{1'b0}}};
    end else if (any_zero) begin
      o_data = {i_sign, 31'h0};
    end else if (exp_n >= EXP_OVF) begin
      o_data  = {i_sign, {EXP_W{1'b1}}, {F{1'b0}}};
      o_flags = 3'b010;
    end else if (exp_n <= EXP_ZERO) begin
      o_data  = {i_sign, 31'h0};
      o_flags = 3'b001;
    end else begin
      o_data = {i_sign, exp_n[EXP_W-1:0], mant};
    end
  end

endmodule

// File: rtl/fp32_mul_seq.sv
// Sequential fp32 multiplier: shift-and-add mantissa product over 24
// cycles, then one normalize/round cycle. Rounding mode is chosen by
// FP_MUL_ROUND_EN inside fp_mul_round.
module fp32_mul_seq
  import fp_mul_pkg::*;
#(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_data_one,
  input  logic [31:0] i_data_two,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_data,
  output logic [2:0]  o_flags
);

  localparam int SE_W  = EXP_W + 2;
  localparam int CNT_W = $clog2(MANT_W);

  state_t                 state, state_nx;
  fp32_t                  op_a, op_b;
  logic                   sign_q;
  logic signed [SE_W-1:0] exp_q;
  cls_t                   cls_a, cls_b;
  logic [MANT_W-1:0]      mcand, mplr, acc, addend, sum;
  logic                   cout;
  logic [CNT_W-1:0]       cnt;
  logic [31:0]            rnd_data;
  logic [2:0]             rnd_flags;

  assign op_a    = i_data_one;
  assign op_b    = i_data_two;
  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign addend  = mplr[0] ? mcand : '0;

  fp_mul_rca #(.W(MANT_W)) u_rca (
    .i_a    (acc),
    .i_b    (addend),
    .i_cin  (1'b0),
    .o_sum  (sum),
    .o_cout (cout)
  );

  fp_mul_round #(.MANT_W(MANT_W), .EXP_W(EXP_W)) u_round (
    .i_prod  ({acc, mplr}),
    .i_exp   (exp_q),
    .i_sign  (sign_q),
    .i_cls_a (cls_a),
    .i_cls_b (cls_b),
    .o_data  (rnd_data),
    .o_flags (rnd_flags)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state: fixed 24 MUL cycles regardless of operand class.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_valid) state_nx = MUL;
      MUL:     if (cnt == '0) state_nx = NORM;
      NORM:    state_nx = DONE;
      DONE:    if (i_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, shift-and-add accumulate, result register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sign_q  <= 1'b0;
      exp_q   <= '0;
      cls_a   <= ZERO;
      cls_b   <= ZERO;
      mcand   <= '0;
      mplr    <= '0;
      acc     <= '0;
      cnt     <= '0;
      o_data  <= '0;
      o_flags <= '0;
    end else begin
      case (state)
        IDLE: if (i_valid) begin
          sign_q <= op_a.sign ^ op_b.sign;
          exp_q  <= SE_W'(op_a.exp) + SE_W'(op_b.exp) - SE_W'(EXP_BIAS);
          cls_a  <= classify(op_a);
          cls_b  <= classify(op_b);
          mcand  <= (op_a.exp == '0) ? '0 : {1'b1, op_a.frac};
          mplr   <= (op_b.exp == '0) ? '0 : {1'b1, op_b.frac};
          acc    <= '0;
          cnt    <= CNT_W'(MANT_W - 1);
        end
        MUL: begin
          {acc, mplr} <= {cout, sum, mplr[MANT_W-1:1]};
          cnt         <= cnt - 1'b1;
        end
        NORM: begin
          o_data  <= rnd_data;
          o_flags <= rnd_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_mul_seq.sv
// Self-checking bench: directed cases, backpressure, mid-op reset and
// randomized operands against an integer-arithmetic reference.
module tb_fp32_mul_seq;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic [31:0] i_data_one = '0;
  logic [31:0] i_data_two = '0;
  logic        o_ready, o_valid;
  logic [31:0] o_data;
  logic [2:0]  o_flags;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  fp32_mul_seq dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data_one (i_data_one),
    .i_data_two (i_data_two),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_flags    (o_flags)
  );

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  // Reference: {flags, data} from plain integer arithmetic.
  function automatic logic [34:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, sh;
    logic s, za, zb, ia, ib, na, nb;
    longint unsigned ma, mb, p, q;
`ifdef FP_MUL_ROUND_EN
    longint unsigned rem, half;
`endif
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    if (na || nb || (ia && zb) || (ib && za)) return {3'b100, 32'h7FC00000};
    if (ia || ib) return {3'b000, s, 8'hFF, 23'h0};
    if (za || zb) return {3'b000, s, 31'h0};
    ma = 64'h800000 | 64'(a[22:0]);
    mb = 64'h800000 | 64'(b[22:0]);
    p  = ma * mb;
    e  = ea + eb - 127;
    sh = 23;
    if (p >= (64'd1 << 47)) begin
      sh = 24;
      e++;
    end
    q = p >> sh;
`ifdef FP_MUL_ROUND_EN
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q++;
    if (q == (64'd1 << 24)) begin
      q = 64'd1 << 23;
      e++;
    end
`endif
    if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
    if (e <= 0)   return {3'b001, s, 31'h0};
    return {3'b000, s, 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0]  e;
    logic [22:0] f;
    int          k;
    k = $urandom_range(0, 9);
    f = 23'($urandom);
    case (k)
      0: e = 8'h00;
      1: begin
        e = 8'hFF;
        if ($urandom_range(0, 1) == 1) f = '0;
      end
      2: e = 8'($urandom_range(1, 20));
      3: e = 8'($urandom_range(230, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, f};
  endfunction

  // One transaction: wait for ready, accept, count to o_valid, then handshake.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [34:0] r, output int lat);
    int n;
    n = 0;
    @(negedge i_clk);
    while (!o_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    i_valid = 1'b1;
    i_data_one = a;
    i_data_two = b;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 100) begin
      @(posedge i_clk); #1;
      lat++;
    end
    r = {o_flags, o_data};
    @(negedge i_clk);
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
  endtask

  logic [31:0] da [9] = '{32'h3FC00000, 32'h3F800001, 32'h7F000000, 32'h00800000,
                          32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h80000000, 32'hFF800000};
  logic [31:0] db [9] = '{32'h40000000, 32'h3FC00000, 32'h40000000, 32'h00800000,
                          32'h00000000, 32'h40000000, 32'h3F800000, 32'h40000000, 32'hFF800000};
`ifdef FP_MUL_ROUND_EN
  localparam logic [31:0] TIE_RES = 32'h3FC00002;
`else
  localparam logic [31:0] TIE_RES = 32'h3FC00001;
`endif
  logic [34:0] dexp [9] = '{{3'b000, 32'h40400000}, {3'b000, TIE_RES}, {3'b010, 32'h7F800000},
                            {3'b001, 32'h00000000}, {3'b100, 32'h7FC00000}, {3'b000, 32'hFF800000},
                            {3'b100, 32'h7FC00000}, {3'b000, 32'h80000000}, {3'b000, 32'h7F800000}};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [34:0] r;
    logic [31:0] a, b;
    int lat, n;

    #12;
    chk("reset_state", {3'b0, o_ready, o_valid, o_flags, o_data}, {3'b0, 1'b1, 1'b0, 3'b000, 32'h0});
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Directed cases.
    for (int i = 0; i < 9; i++) begin
      do_op(da[i], db[i], r, lat);
      chk($sformatf("dir%0d", i), 40'(r), 40'(dexp[i]));
      chk($sformatf("dir%0d_lat", i), 40'(lat), 40'd26);
    end
    chk("post_hs", {38'h0, o_ready, o_valid}, {38'h0, 1'b1, 1'b0});

    // Backpressure with i_valid held high and operands changing mid-op.
    @(negedge i_clk);
    i_valid = 1'b1;
    i_data_one = 32'h3FC00000;
    i_data_two = 32'h40000000;
    @(posedge i_clk); #1;
    chk("bp_accept", 40'(o_ready), 40'd0);
    i_data_one = 32'h40400000;
    i_data_two = 32'h40000000;
    n = 0;
    while (!o_valid && n < 100) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk("bp_lat", 40'(n), 40'd25);
    for (int k = 0; k < 10; k++) begin
      @(posedge i_clk); #1;
      chk("bp_hold", {o_valid, o_ready, 3'b0, o_flags, o_data}, {1'b1, 1'b0, 3'b0, 3'b000, 32'h40400000});
    end
    @(negedge i_clk);
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    chk("bp_idle", {38'h0, o_ready, o_valid}, {38'h0, 1'b1, 1'b0});
    @(posedge i_clk); #1;
    chk("bp_second_acc", 40'(o_ready), 40'd0);
    i_valid = 1'b0;
    n = 1;
    while (!o_valid && n < 100) begin
      @(posedge i_clk); #1;
      n++;
    end
    chk("bp_second_lat", 40'(n), 40'd26);
    chk("bp_second", {5'h0, o_flags, o_data}, {5'h0, 3'b000, 32'h40C00000});
    @(negedge i_clk);
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;

    // Reset during MUL, then a clean operation.
    @(negedge i_clk);
    i_valid = 1'b1;
    i_data_one = 32'h3F800001;
    i_data_two = 32'h3FC00000;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (12) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rst_mid", {3'b0, o_ready, o_valid, o_flags, o_data}, {3'b0, 1'b1, 1'b0, 3'b000, 32'h0});
    @(negedge i_clk);
    i_rst_n = 1'b1;
    do_op(32'h3FC00000, 32'h40000000, r, lat);
    chk("rst_after", 40'(r), {5'h0, 3'b000, 32'h40400000});
    chk("rst_after_lat", 40'(lat), 40'd26);

    // Randomized operands against the reference.
    for (int i = 0; i < 40; i++) begin
      a = rnd_op();
      b = rnd_op();
      do_op(a, b, r, lat);
      chk($sformatf("rnd%0d %h*%h", i, a, b), 40'(r), 40'(ref_mul(a, b)));
      chk($sformatf("rnd%0d_lat", i), 40'(lat), 40'd26);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp32_mul_seq.md
# fp32_mul_seq

- Sequential IEEE-754 single-precision multiplier built around the team's ripple-carry adder chain.
- Accepts two packed operands over a valid/ready handshake.
- Forms the 48-bit mantissa product by iterative shift-and-add, one partial product per cycle, with the accumulate feeding the adder stage.
- Normalizes, rounds and packs the result. It is the datapath core of the floating-point multiplication top level.

## Interface
Parameters:
- MANT_W, 24, significand width including hidden bit (fixed for fp32; not for override)
- EXP_W, 8, exponent width

Ports:
- i_clk  in  1  single clock; all state on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  operands present
- o_ready  out  1  block can accept operands (high only in IDLE)
- i_data_one  in  32  operand A, IEEE-754 fp32
- i_data_two  in  32  operand B, IEEE-754 fp32
- o_valid  out  1  result present; held until consumed
- i_ready  in  1  downstream accepts result
- o_data  out  32  product, IEEE-754 fp32
- o_flags  out  3  {invalid, overflow, underflow}, valid with o_valid

## Operation
- FSM states: IDLE → MUL → NORM → DONE → IDLE.
- IDLE:
  - o_ready=1.
  - On i_valid&&o_ready: latch operands, compute sign = sa^sb and exponent sum ea+eb−127 in 10-bit signed, classify specials, load multiplicand/multiplier, clear accumulator, counter=23. Go to MUL.
- MUL:
  - Each cycle: if multiplier LSB=1, add the multiplicand to the upper accumulator half.
  - Shift {carry,acc,multiplier} right 1 and decrement the counter.
  - After the counter=0 cycle (24 cycles total), go to NORM.
- NORM:
  - If product bit47=1, take mantissa bits[46:24] and exp+1; else take bits[45:23].
  - Round, then apply special/range overrides.
  - Register o_data/o_flags and go to DONE.
- DONE:
  - o_valid=1. o_data/o_flags are stable.
  - On i_ready, go to IDLE; o_valid drops the next cycle.
- Operand classes:
  - exp=0 → zero; subnormals are flushed to zero.
  - exp=255, frac=0 → inf.
  - exp=255, frac≠0 → NaN.
- Special results, in priority order:
  - Any NaN, or inf×zero → 0x7FC00000, invalid=1.
  - inf×finite-nonzero or inf×inf → signed inf.
  - zero×finite → signed zero.
- Range:
  - Final biased exponent ≥255 → signed inf (0x7F800000|sign), overflow=1.
  - Final exponent ≤0 → signed zero, underflow=1.
- Fixed latency: special cases still traverse MUL/NORM.
- o_ready=0 outside IDLE; i_valid is ignored there.
- Reset mid-operation aborts immediately: state IDLE, accumulator cleared.

## Timing
- Reset values: o_ready=1, o_valid=0, o_data=0x00000000, o_flags=3'b000, FSM=IDLE.
- Accept edge T. MUL covers edges T+1..T+24, NORM edge T+25. o_valid is high after edge T+25, i.e. 26 cycles accept→result.
- Throughput: one result per 27 cycles minimum, including the IDLE cycle after the DONE handshake.
- Backpressure: DONE holds indefinitely while i_ready=0. Outputs must not change.
- i_ready while not in DONE has no effect.

## Configuration
- FP_MUL_ROUND_EN defined:
  - Round-to-nearest-even. guard = first discarded bit, sticky = OR of the remaining discarded bits.
  - Increment when guard&&(sticky||lsb).
  - If the mantissa carries out, set mantissa=0 and exp+1, then re-check overflow.
- Undefined: truncation (round toward zero); discarded bits ignored.

## Structure
- Package fp_mul_pkg:
  - Constants EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000.
  - FSM enum typedef (IDLE, MUL, NORM, DONE).
  - fp32 struct typedef {sign, exp[7:0], frac[22:0]}.
  - Operand-class enum (ZERO, NORMAL, INF, NAN).
- Sub-module fp_mul_round: combinational normalize + round + range/special override. Inputs: 48-bit product, 10-bit exponent, sign, class info. Outputs: o_data, o_flags. The macro is applied inside this module.
- Mantissa accumulate uses the existing ripple adder chain, 24-bit plus carry.

## Test plan
- 0x3FC00000 × 0x40000000 (1.5×2) → 0x40400000, flags 000, o_valid exactly 26 cycles after accept.
- 0x3F800001 × 0x3FC00000 (tie, odd LSB) → 0x3FC00002 with FP_MUL_ROUND_EN; 0x3FC00001 without.
- 0x7F000000 × 0x40000000 → 0x7F800000, overflow=1; 0x00800000 × 0x00800000 → 0x00000000, underflow=1.
- 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1; 0xFF800000 × 0x40000000 → 0xFF800000, flags 000.
- i_ready held low 10 cycles in DONE with i_valid high → o_data stable, o_ready=0, second operand accepted only after the handshake plus IDLE.
- i_rst_n pulsed low at MUL cycle 12 → o_valid=0, o_ready=1, o_data=0 immediately. The next operation (1.5×2) yields a correct 0x40400000.
